issue_queue: RTL and testbench

ISSUE_QUEUE -- requirements
Module: issue_queue

---
 rtl/viola_pkg.sv | 18 +
 rtl/issue_queue_if.sv | 39 +++
 rtl/iq_ptr_ctrl.sv | 41 ++++
 rtl/issue_queue.sv | 89 ++++++++
 tb/tb_issue_queue.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/viola_pkg.sv
// Shared issue-queue types and defaults: opcode/register/immediate widths,
// the all-ones NOP encoding and the packed issue-queue entry.
package viola_pkg;
  localparam int IQ_OP_W  = 5;
  localparam int IQ_REG_W = 5;
  localparam int IQ_IMM_W = 32;

  localparam logic [IQ_OP_W-1:0] OP_NOP = '1;

  typedef struct packed {
    logic [IQ_OP_W-1:0]  op;
    logic [IQ_REG_W-1:0] rs1;
    logic [IQ_REG_W-1:0] rs2;
    logic [IQ_REG_W-1:0] rd;
    logic [IQ_IMM_W-1:0] imm;
    logic                has_imm;
  } iq_entry_t;
endpackage

// File: rtl/issue_queue_if.sv
// Enqueue/dispatch handshake bundle for the issue queue.
// master = decode/dispatch side, slave = the queue itself.
interface issue_queue_if
  import viola_pkg::*;
#(
  parameter int OP_W  = IQ_OP_W,
  parameter int REG_W = IQ_REG_W,
  parameter int IMM_W = IQ_IMM_W
);
  logic             enq_valid;
  logic             enq_ready;
  logic [OP_W-1:0]  enq_op;
  logic [REG_W-1:0] enq_rs1, enq_rs2, enq_rd;
  logic [IMM_W-1:0] enq_imm;
  logic             enq_has_imm;

  logic             rs_full;
  logic             rob_full;

  logic             deq_valid;
  logic [OP_W-1:0]  deq_op;
  logic [REG_W-1:0] deq_rs1, deq_rs2, deq_rd;
  logic [IMM_W-1:0] deq_imm;
  logic             deq_has_imm;

  modport master (
    output enq_valid, enq_op, enq_rs1, enq_rs2, enq_rd, enq_imm, enq_has_imm,
    output rs_full, rob_full,
    input  enq_ready,
    input  deq_valid, deq_op, deq_rs1, deq_rs2, deq_rd, deq_imm, deq_has_imm
  );

  modport slave (
    input  enq_valid, enq_op, enq_rs1, enq_rs2, enq_rd, enq_imm, enq_has_imm,
    input  rs_full, rob_full,
    output enq_ready,
    output deq_valid, deq_op, deq_rs1, deq_rs2, deq_rd, deq_imm, deq_has_imm
  );
endinterface

// File: rtl/iq_ptr_ctrl.sv
// Head/tail/occupancy tracking for the issue queue. Full/empty come from
// count only; pointers wrap naturally at log2(DEPTH) bits.
module iq_ptr_ctrl #(
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  output logic [PTR_W-1:0] head,
  output logic [PTR_W-1:0] tail,
  output logic [CNT_W-1:0] count
);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic do_push, do_pop;

  // Guard against overflow/underflow even if the caller misbehaves.
  assign do_push = push && (count != FULL);
  assign do_pop  = pop  && (count != '0);

  // Reset and flush both return to empty; otherwise advance on push/pop.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/issue_queue.sv
// In-order issue queue, first-word-fall-through head presentation.
// Optional same-cycle bypass into an empty queue: define ISSUE_QUEUE_BYPASS_EN.
module issue_queue
  import viola_pkg::*;
#(
  parameter  int DEPTH     = 16,
  parameter  int OP_W      = IQ_OP_W,
  parameter  int REG_W     = IQ_REG_W,
  parameter  int IMM_W     = IQ_IMM_W,
  parameter  int AF_MARGIN = 1,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  issue_queue_if.slave     io,
  output logic [CNT_W-1:0] count,
  output logic             iq_full
);
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic [IMM_W-1:0] imm;
    logic             has_imm;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           enq_e, deq_e;
  logic [PTR_W-1:0] head, tail;
  logic             have, stall, enq_fire, bypass, push, pop;

  assign have     = (count != '0);
  assign stall    = io.rs_full || io.rob_full;
  // No credit from a same-cycle dequeue: only free space counts.
  assign io.enq_ready = (count < CNT_W'(DEPTH));
  assign enq_fire = io.enq_valid && io.enq_ready;
  assign iq_full  = (count >= CNT_W'(DEPTH - AF_MARGIN));

`ifdef ISSUE_QUEUE_BYPASS_EN
  // Empty queue and a free dispatch slot: forward the incoming entry directly.
  assign bypass = !have && enq_fire && !stall && !flush && rst;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed entry dispatches immediately and is never written to storage.
  assign push = enq_fire && !bypass;
  assign pop  = have && !stall;

  // Nothing dispatches in a reset or flush cycle; both discard the queue.
  assign io.deq_valid = rst && !flush && (have || bypass);

  assign enq_e = '{op: io.enq_op, rs1: io.enq_rs1, rs2: io.enq_rs2, rd: io.enq_rd,
                   imm: io.enq_imm, has_imm: io.enq_has_imm};

  iq_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .head  (head),
    .tail  (tail),
    .count (count)
  );

  // Entry storage; contents are left as-is on reset/flush, pointers make them dead.
  always_ff @(posedge clk) begin
    if (rst && !flush && push) mem[tail] <= enq_e;
  end

  // Payload mux: bypass, stored head, or NOP with zeroed fields when idle.
  always_comb begin
    deq_e    = '0;
    deq_e.op = '1;
    if (bypass)            deq_e = enq_e;
    else if (io.deq_valid) deq_e = mem[head];
  end

  assign io.deq_op      = deq_e.op;
  assign io.deq_rs1     = deq_e.rs1;
  assign io.deq_rs2     = deq_e.rs2;
  assign io.deq_rd      = deq_e.rd;
  assign io.deq_imm     = deq_e.imm;
  assign io.deq_has_imm = deq_e.has_imm;
endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: reset, FWFT order, fill/almost-full,
// full-queue wrap, flush, mid-run reset, and bypass when enabled.
module tb_issue_queue;
  import viola_pkg::*;

  localparam int DEPTH = 16;
  localparam int AF    = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic [4:0] count;
  logic       iq_full;

  always #5 clk = ~clk;

  issue_queue_if #(.OP_W(IQ_OP_W), .REG_W(IQ_REG_W), .IMM_W(IQ_IMM_W)) iq_if ();

  issue_queue #(.DEPTH(DEPTH), .OP_W(IQ_OP_W), .REG_W(IQ_REG_W), .IMM_W(IQ_IMM_W),
                .AF_MARGIN(AF)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .io      (iq_if),
    .count   (count),
    .iq_full (iq_full)
  );

  int passed = 0;
  int total  = 0;
  logic [4:0] exp_q[$];

  typedef struct {
    logic       ev;
    logic [4:0] op;
    int         e_cnt;
    logic       e_vld;
    logic [4:0] e_op;
    logic       e_full;
    logic       e_rdy;
  } vec_t;
  vec_t vec[4];

  function automatic logic [31:0] imm_of(logic [4:0] op);
    return {16'hC0DE, 3'b0, op, 3'b0, op};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic set_enq(logic v, logic [4:0] op);
    iq_if.enq_valid   = v;
    iq_if.enq_op      = op;
    iq_if.enq_rs1     = op;
    iq_if.enq_rs2     = ~op;
    iq_if.enq_rd      = op + 5'd2;
    iq_if.enq_imm     = imm_of(op);
    iq_if.enq_has_imm = op[0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock with the given enqueue, then inputs return to idle for checking.
  task automatic step(logic v, logic [4:0] op);
    set_enq(v, op);
    tick();
    set_enq(1'b0, 5'd0);
    flush = 1'b0;
    #1;
  endtask

  task automatic chk_head(string n, logic [4:0] op);
    chk({n, ".vld"},  iq_if.deq_valid, 1);
    chk({n, ".op"},   iq_if.deq_op, op);
    chk({n, ".rs1"},  iq_if.deq_rs1, op);
    chk({n, ".rs2"},  iq_if.deq_rs2, 5'(~op));
    chk({n, ".rd"},   iq_if.deq_rd, 5'(op + 5'd2));
    chk({n, ".imm"},  iq_if.deq_imm, imm_of(op));
    chk({n, ".himm"}, iq_if.deq_has_imm, op[0]);
  endtask

  task automatic chk_idle(string n);
    chk({n, ".vld"},  iq_if.deq_valid, 0);
    chk({n, ".op"},   iq_if.deq_op, 5'h1F);
    chk({n, ".rs1"},  iq_if.deq_rs1, 0);
    chk({n, ".rd"},   iq_if.deq_rd, 0);
    chk({n, ".imm"},  iq_if.deq_imm, 0);
    chk({n, ".himm"}, iq_if.deq_has_imm, 0);
  endtask

  initial begin
    set_enq(1'b0, 5'd0);
    iq_if.rs_full  = 1'b0;
    iq_if.rob_full = 1'b0;

    // Reset state
    tick();
    set_enq(1'b1, 5'd4);
    tick();
    chk("rst.count", count, 0);
    chk("rst.iq_full", iq_full, 0);
    chk("rst.enq_ready", iq_if.enq_ready, 1);
    chk_idle("rst");
    set_enq(1'b0, 5'd0);
    rst = 1'b1;
    tick();
    chk("rst.count_after", count, 0);

`ifdef ISSUE_QUEUE_BYPASS_EN
    // Bypass into an empty queue: same-cycle dispatch, nothing stored
    set_enq(1'b1, 5'd7);
    #1;
    chk("byp.vld", iq_if.deq_valid, 1);
    chk("byp.op", iq_if.deq_op, 7);
    chk("byp.imm", iq_if.deq_imm, imm_of(5'd7));
    tick();
    set_enq(1'b0, 5'd0);
    #1;
    chk("byp.count", count, 0);
    chk_idle("byp.after");
    // Stalled dispatch: entry is stored instead
    iq_if.rs_full = 1'b1;
    set_enq(1'b1, 5'd7);
    #1;
    chk("byp_stall.vld", iq_if.deq_valid, 0);
    tick();
    set_enq(1'b0, 5'd0);
    #1;
    chk("byp_stall.count", count, 1);
    chk_head("byp_stall.head", 5'd7);
    iq_if.rs_full = 1'b0;
    tick();
    chk("byp_stall.drain", count, 0);
`else
    // Back-to-back ops 1,2,3 appear on cycles 1,2,3 after the first enqueue
    vec[0] = '{1'b1, 5'd1, 1, 1'b1, 5'd1, 1'b0, 1'b1};
    vec[1] = '{1'b1, 5'd2, 1, 1'b1, 5'd2, 1'b0, 1'b1};
    vec[2] = '{1'b1, 5'd3, 1, 1'b1, 5'd3, 1'b0, 1'b1};
    vec[3] = '{1'b0, 5'd0, 0, 1'b0, 5'h1F, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      step(vec[i].ev, vec[i].op);
      chk($sformatf("vec%0d.count", i), count, vec[i].e_cnt);
      chk($sformatf("vec%0d.iq_full", i), iq_full, vec[i].e_full);
      chk($sformatf("vec%0d.enq_ready", i), iq_if.enq_ready, vec[i].e_rdy);
      if (vec[i].e_vld) chk_head($sformatf("vec%0d", i), vec[i].e_op);
      else              chk_idle($sformatf("vec%0d", i));
    end
`endif

    // Fill 16 entries with dispatch stalled
    iq_if.rob_full = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 5'(i));
      exp_q.push_back(5'(i));
      chk($sformatf("fill%0d.count", i), count, i + 1);
      chk($sformatf("fill%0d.iq_full", i), iq_full, (i + 1) >= (DEPTH - AF));
      chk($sformatf("fill%0d.enq_ready", i), iq_if.enq_ready, (i + 1) < DEPTH);
    end
    // 17th enqueue is refused
    set_enq(1'b1, 5'd30);
    #1;
    chk("full.enq_ready_pre", iq_if.enq_ready, 0);
    tick();
    set_enq(1'b0, 5'd0);
    #1;
    chk("full.count", count, 16);
    chk_head("full.head", exp_q[0]);

    // Full queue with enq_valid and dispatch: dequeue only
    set_enq(1'b1, 5'd20);
    iq_if.rob_full = 1'b0;
    tick();
    void'(exp_q.pop_front());
    set_enq(1'b0, 5'd0);
    #1;
    chk("fulldq.count", count, 15);
    chk("fulldq.enq_ready", iq_if.enq_ready, 1);
    chk_head("fulldq.head", exp_q[0]);

    // Concurrent enq+deq across the pointer wrap; op 31 (NOP) stored like any op
    for (int k = 0; k < DEPTH; k++) begin
      step(1'b1, 5'(16 + k));
      void'(exp_q.pop_front());
      exp_q.push_back(5'(16 + k));
      chk($sformatf("wrap%0d.count", k), count, 15);
      chk_head($sformatf("wrap%0d", k), exp_q[0]);
    end

    // Drain in order
    for (int d = 0; d < 15; d++) begin
      tick();
      void'(exp_q.pop_front());
      if (exp_q.size() > 0) chk_head($sformatf("drain%0d", d), exp_q[0]);
      else                  chk_idle($sformatf("drain%0d", d));
    end
    chk("drain.count", count, 0);

    // Flush with concurrent enqueue at count 5
    iq_if.rob_full = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, 5'(8 + i));
    chk("flush.pre_count", count, 5);
    flush = 1'b1;
    step(1'b1, 5'd3);
    chk("flush.count", count, 0);
    chk_idle("flush");
    step(1'b1, 5'd9);
    chk("flush.reenq_count", count, 1);
    chk_head("flush.reenq", 5'd9);
    iq_if.rob_full = 1'b0;
    tick();
    chk("flush.drain", count, 0);
    chk_idle("flush.drain");

    // Reset mid-operation with enq_valid and dispatch enabled
    iq_if.rob_full = 1'b1;
    step(1'b1, 5'd1);
    step(1'b1, 5'd2);
    step(1'b1, 5'd3);
    chk("mrst.pre_count", count, 3);
    rst = 1'b0;
    iq_if.rob_full = 1'b0;
    set_enq(1'b1, 5'd12);
    #1;
    chk("mrst.vld_in_cycle", iq_if.deq_valid, 0);
    tick();
    rst = 1'b1;
    set_enq(1'b0, 5'd0);
    #1;
    chk("mrst.count", count, 0);
    chk("mrst.enq_ready", iq_if.enq_ready, 1);
    chk("mrst.iq_full", iq_full, 0);
    chk_idle("mrst");
    iq_if.rob_full = 1'b1;
    step(1'b1, 5'd13);
    chk("mrst.reenq_count", count, 1);
    chk_head("mrst.reenq", 5'd13);
    iq_if.rob_full = 1'b0;
    tick();
    chk("mrst.drain", count, 0);
    chk_idle("mrst.drain");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
